// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage of the MIPS core.
// Holds the architectural PC and selects the next PC from jump, branch and
// sequential targets. A one-cycle boot bubble follows reset. A target
// outside the instruction memory traps into a sticky fault state.
// Optional macro PC_SEQ_STATS_EN adds the taken-branch and jump counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0040_0000,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        branch_eq_i,
    input  logic        branch_ne_i,
    input  logic        jmp_i,
    input  logic        zero_i,
    input  logic [31:0] imm_i,
    input  logic [25:0] jump_addr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        pc_valid_o,
    output logic        redirect_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
`ifdef PC_SEQ_STATS_EN
    ,
    output logic [31:0] taken_cnt_o,
    output logic [31:0] jump_cnt_o
`endif
);

    localparam logic [1:0] ST_BOOT  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_JUMP   = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;

    // A target is legal when its offset from RESET_ADDR lies inside the
    // memory; the unsigned subtraction also rejects addresses below the base.
    function automatic logic f_in_range(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - RESET_ADDR;
        return (offset < 32'(IMEM_BYTES));
    endfunction

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_pc_valid;
    logic        r_fault;
    logic [31:0] r_fault_pc;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_target;
    logic [1:0]  w_sel;
    logic        w_in_range;
    logic        w_advance;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_jump_tgt   = {w_pc_plus4[31:28], jump_addr_i, 2'b00};
    assign w_branch_tgt = w_pc_plus4 + {imm_i[29:0], 2'b00};

    // Next-PC selection: jump first, then either taken branch, else pc+4.
    always_comb begin
        w_sel    = SEL_SEQ;
        w_target = w_pc_plus4;
        if (jmp_i) begin
            w_sel    = SEL_JUMP;
            w_target = w_jump_tgt;
        end else if ((branch_eq_i & zero_i) | (branch_ne_i & ~zero_i)) begin
            w_sel    = SEL_BRANCH;
            w_target = w_branch_tgt;
        end else begin
            w_sel    = SEL_SEQ;
            w_target = w_pc_plus4;
        end
    end

    assign w_in_range = f_in_range(w_target);
    // r_pc_valid is high exactly in RUN, so it doubles as the run qualifier.
    assign w_advance  = r_pc_valid & ~stall_i;

    assign pc_o       = r_pc;
    assign pc_plus4_o = w_pc_plus4;
    assign pc_valid_o = r_pc_valid;
    assign redirect_o = w_advance & (w_sel != SEL_SEQ);
    assign fault_o    = r_fault;
    assign fault_pc_o = r_fault_pc;

    // PC, state machine and fault capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_ADDR;
            r_pc_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'd0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_RUN;
                    r_pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (!stall_i) begin
                        if (w_in_range) begin
                            r_pc <= w_target;
                        end else begin
                            r_state    <= ST_FAULT;
                            r_pc_valid <= 1'b0;
                            r_fault    <= 1'b1;
                            r_fault_pc <= w_target;
                        end
                    end
                end
                ST_FAULT: begin
                    r_pc_valid <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: park safely in FAULT.
                    r_state    <= ST_FAULT;
                    r_pc_valid <= 1'b0;
                    r_fault    <= 1'b1;
                end
            endcase
        end
    end

`ifdef PC_SEQ_STATS_EN
    logic [31:0] r_taken_cnt;
    logic [31:0] r_jump_cnt;

    assign taken_cnt_o = r_taken_cnt;
    assign jump_cnt_o  = r_jump_cnt;

    // Count redirects that actually commit (not stalled, not faulting).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_taken_cnt <= 32'd0;
            r_jump_cnt  <= 32'd0;
        end else if (w_advance && w_in_range) begin
            if (w_sel == SEL_BRANCH) begin
                r_taken_cnt <= r_taken_cnt + 32'd1;
            end
            if (w_sel == SEL_JUMP) begin
                r_jump_cnt <= r_jump_cnt + 32'd1;
            end
        end
    end
`else
    // Statistics build option disabled: no counter state exists.
`endif

endmodule
